// File: rtl/jk_ff_bank.sv
// ============================================================================
// Module      : jk_ff_bank
// Description : Bank of WIDTH flops with runtime JK/D/T/SR modes, parallel
//               load, registered edge pulses, change counter and SR flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [1:0]       c_MODE_JK = 2'b00;
    localparam logic [1:0]       c_MODE_D  = 2'b01;
    localparam logic [1:0]       c_MODE_T  = 2'b10;
    localparam logic [1:0]       c_MODE_SR = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_chg_cnt;
    logic             r_sr_err;

    logic [WIDTH-1:0] w_q_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sr_illegal;
    logic             w_changed;

    // SR: S&~R sets, R&~S clears, equal inputs (00 or illegal 11) hold.
    always_comb begin
        w_q_mode = r_q;
        case (mode)
            c_MODE_JK: w_q_mode = (j & ~r_q) | (~k & r_q);
            c_MODE_D:  w_q_mode = j;
            c_MODE_T:  w_q_mode = r_q ^ j;
            c_MODE_SR: w_q_mode = (j & ~k) | (r_q & ~(j ^ k));
            default:   w_q_mode = r_q;
        endcase
    end

    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = load_val;
        end else if (en) begin
            w_q_next = w_q_mode;
        end
    end

    assign w_sr_illegal = en && !load && (mode == c_MODE_SR) && (|(j & k));
    assign w_changed    = (w_q_next != r_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RST_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_chg_cnt <= '0;
            r_sr_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_rise <= ~r_q & w_q_next;
            r_fall <= r_q & ~w_q_next;
            if (w_changed && (r_chg_cnt != c_CNT_MAX)) begin
                r_chg_cnt <= r_chg_cnt + 1'b1;
            end
            if (w_sr_illegal) begin
                r_sr_err <= 1'b1;
            end
        end
    end

    assign q       = r_q;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign chg_cnt = r_chg_cnt;
    assign sr_err  = r_sr_err;

endmodule

`default_nettype wire

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
- Parametrised, multi-channel successor to the single JK flip-flop: a bank of WIDTH flops sharing one clock, reset, enable and mode.
- Runtime-selectable JK / D / T / SR update modes, synchronous parallel load, and per-bit registered rise/fall pulses.
- Saturating change counter and sticky SR-illegal flag.
- Used as a general state/flag register in control paths where per-bit set/clear/toggle semantics are needed.

Parameters:
- WIDTH, 8, number of flop channels.
- CNT_W, 8, width of change counter chg_cnt.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable for mode-driven updates.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to q on load.
- mode  input  2  00=JK, 01=D, 10=T, 11=SR.
- j  input  WIDTH  J / D / T / S input per channel, depending on mode.
- k  input  WIDTH  K / R input per channel; ignored in D and T modes.
- q  output  WIDTH  flop state, registered.
- rise  output  WIDTH  1-cycle pulse per bit that went 0->1 on the last edge.
- fall  output  WIDTH  1-cycle pulse per bit that went 1->0 on the last edge.
- chg_cnt  output  CNT_W  count of edges where q changed; saturating.
- sr_err  output  1  sticky flag: SR mode saw S=R=1 on an enabled bit.

Behaviour:
- One clock, rst synchronous active-high. All outputs are registers; no combinational input-to-output path.
- Reset (rst=1 at edge):
  - q=RST_VAL; rise=0, fall=0, chg_cnt=0, sr_err=0.
  - Overrides load and en.
  - Reset mid-operation discards that edge's update.
- Priority per edge: rst > load > en > hold.
- load=1 (rst=0): q_next=load_val regardless of en and mode. Never sets sr_err.
- en=1, load=0: q_next per bit i from mode, sampled on the same edge:
  - JK: q_next = (j & ~q) | (~k & q), so j=k=1 toggles.
  - D: q_next = j.
  - T: q_next = q ^ j.
  - SR (j=S, k=R): 10 -> 1; 01 -> 0; 00 -> hold; 11 -> hold that bit and set sr_err=1.
- en=0, load=0: q holds; no sr_err update regardless of inputs.
- rise = ~q_old & q_next and fall = q_old & ~q_next, registered on the same edge as q.
  - Valid exactly the cycle after the edge.
  - Both 0 on any edge where q is unchanged, including hold and reset.
- chg_cnt:
  - +1 on each non-reset edge where q_next != q_old (any bit, load included).
  - Saturates at 2^CNT_W-1; never wraps.
- sr_err is sticky; cleared only by rst.
- Latency: input to q/rise/fall/chg_cnt/sr_err is 1 cycle.

Test Plan:
- Reset: WIDTH=4, RST_VAL=4'hA, rst=1 with en=1, load=1, load_val=4'h3 -> next cycle q=4'hA, rise=fall=0, chg_cnt=0, sr_err=0.
- JK toggle and pulses: WIDTH=4, q=0, mode=00, en=1, j=4'b0011, k=4'b0101 held 2 edges:
  - Edge 1 -> q=4'b0011, rise=4'b0011.
  - Edge 2 -> q=4'b0010, fall=4'b0001, rise=0, chg_cnt=2.
- T mode saturation: CNT_W=3, mode=10, j=4'b0001, en=1 for 9 edges -> q[0] alternates 1,0,1,...; chg_cnt reaches 7 on edge 7 and stays 7.
- SR illegal:
  - mode=11, j=4'b1000, k=4'b1000, en=1 -> q unchanged, sr_err=1 next cycle.
  - Switch to mode=01 and apply changes -> sr_err stays 1; pulse rst -> sr_err=0.
  - Same S=R input with en=0 -> sr_err stays 0.
- Priority: mode=01, j=4'hF, en=1, load=1, load_val=4'h5 -> q=4'h5. Same plus rst=1 -> q=RST_VAL.
- Hold: en=0, load=0, j/k/mode randomised 10 cycles -> q, chg_cnt constant; rise=fall=0 every cycle.
